// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined FP multiplier between two requesters.
// A {valid, owner} tag pipe aligned with the multiplier latency steers each product home.
module fp_mul_arbiter #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  output logic             req1_ready,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic [31:0]      mul_c,
  output logic             rsp0_valid,
  output logic [31:0]      rsp0_c,
  output logic             rsp1_valid,
  output logic [31:0]      rsp1_c,
  input  logic             drain,
  output logic             idle,
  output logic [CNT_W-1:0] in_flight
);

  typedef enum logic {RUN, DRAIN} state_e;

  state_e             state_q, state_d;
  logic               prio_q, prio_d;
  logic [MUL_LAT-1:0] tag_v_q, tag_v_d;
  logic [MUL_LAT-1:0] tag_id_q, tag_id_d;
  logic [CNT_W-1:0]   in_flight_q, in_flight_d;

  logic grant;
  logic grant_id;
  logic retire;

  always_comb begin
    grant    = 1'b0;
    grant_id = 1'b0;
    if (!rst && !drain && (state_q == RUN)) begin
      if (req0_valid && req1_valid) begin
        grant    = 1'b1;
        grant_id = prio_q;
      end else if (req0_valid) begin
        grant    = 1'b1;
        grant_id = 1'b0;
      end else if (req1_valid) begin
        grant    = 1'b1;
        grant_id = 1'b1;
      end
    end
  end

  assign retire = tag_v_q[MUL_LAT-1];

  always_comb begin
    state_d     = drain ? DRAIN : RUN;
    prio_d      = grant ? ~grant_id : prio_q;
    tag_v_d     = '0;
    tag_id_d    = '0;
    tag_v_d[0]  = grant;
    tag_id_d[0] = grant_id;
    for (int unsigned i = 1; i < MUL_LAT; i++) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end
    in_flight_d = in_flight_q;
    if (grant && !retire)
      in_flight_d = in_flight_q + CNT_W'(1);
    else if (!grant && retire)
      in_flight_d = in_flight_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      prio_q      <= 1'b0;
      tag_v_q     <= '0;
      tag_id_q    <= '0;
      in_flight_q <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      tag_v_q     <= tag_v_d;
      tag_id_q    <= tag_id_d;
      in_flight_q <= in_flight_d;
    end
  end

  assign req0_ready = grant && !grant_id;
  assign req1_ready = grant &&  grant_id;

  // Bubbles go in as zero operands; their tag is invalid so the product is ignored.
  assign mul_a = grant ? (grant_id ? req1_a : req0_a) : '0;
  assign mul_b = grant ? (grant_id ? req1_b : req0_b) : '0;

  assign rsp0_valid = retire && !tag_id_q[MUL_LAT-1];
  assign rsp1_valid = retire &&  tag_id_q[MUL_LAT-1];
  assign rsp0_c     = mul_c;
  assign rsp1_c     = mul_c;

  assign in_flight = in_flight_q;
  assign idle      = (in_flight_q == '0) && !grant;

endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Round-robin arbiter that shares one pipelined floating-point `multiplier` between two requesters. Each requester presents IEEE-754 single-precision operand pairs on a valid/ready handshake. The arbiter drives the multiplier inputs, tracks which requester owns each in-flight operation in a tag pipeline matched to the multiplier latency, and steers each result back to its owner. It sits between the requester-side logic and the `multiplier` instance, and supports a drain mode for orderly quiescing.

## Interface
- MUL_LAT, 4, cycles from operands presented on `mul_a`/`mul_b` to the product valid on `mul_c`; must equal the multiplier pipeline depth, and must be at least 1
- CNT_W, 3, width of `in_flight`; must satisfy 2^CNT_W > MUL_LAT
- clk  input  1  single clock, all logic rising-edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an operand pair
- req0_a, req0_b  input  32  requester 0 operands
- req0_ready  output  1  requester 0 operands accepted this cycle
- req1_valid, req1_a, req1_b, req1_ready  same as requester 0, for requester 1
- mul_a, mul_b  output  32  operands to the multiplier
- mul_c  input  32  product from the multiplier
- rsp0_valid, rsp1_valid  output  1  product for requester 0 / 1 is on `rsp*_c` this cycle
- rsp0_c, rsp1_c  output  32  product, which is `mul_c` passed through
- drain  input  1  stop issuing new operations
- idle  output  1  no operation in flight and no grant this cycle
- in_flight  output  CNT_W  number of operations currently in the multiplier

## Operation
- **Handshake:** a transfer occurs when `reqN_valid && reqN_ready`. A requester holds valid and its operands stable until ready is seen. `reqN_ready` is combinational from the grant, and at most one ready is high per cycle.
- **Grant:** no grant while `rst` or `drain` is high, and no grant in state DRAIN.
  - Only one requester valid: grant it.
  - Both valid: grant the requester selected by the priority pointer `prio`.
- **Priority pointer:** after any grant, `prio` points to the non-granted requester, for strict alternation under contention. With no grant, `prio` holds. Reset value is 0.
- **Operand drive:** on a granted cycle, `mul_a`/`mul_b` carry the granted operands. Otherwise they carry 0x00000000, and that bubble is tagged invalid.
- **Tag pipeline:** a MUL_LAT-deep shift register of {valid, owner}. Stage 0 loads {grant, granted id} each cycle, and the last stage is aligned with `mul_c`.
  - `rspN_valid` = last-stage valid && owner == N.
  - `rsp0_c` and `rsp1_c` are always driven with `mul_c`.
  - There is no response backpressure, so requesters must accept the response in the cycle it appears.
- **in_flight counter:** +1 on grant, −1 when the last stage is valid, unchanged when both happen in the same cycle. It never exceeds MUL_LAT.
- **State machine:**
  - RUN (reset state): grants allowed. When `drain` is 1, go to DRAIN.
  - DRAIN: no grants; in-flight results still retire normally. When `drain` is 0, go back to RUN.
- **idle** = (in_flight == 0) && no grant this cycle.
- **Reset mid-operation:** tag pipe, counter, `prio` and state all clear. Products still inside the multiplier are discarded, so no `rsp*_valid` is asserted for them.

## Timing
- Reset values: `req*_ready`=0, `rsp*_valid`=0, `mul_a`=`mul_b`=0, `in_flight`=0, `idle`=1, `prio`=0, state RUN.
- Grant in cycle t: the multiplier samples the operands at the rising edge ending cycle t, and `rspN_valid`/`rspN_c` are asserted in cycle t+MUL_LAT.
- Throughput is one grant per cycle overall. Under continuous contention each requester gets every other cycle.
- `drain` is sampled combinationally for the grant, so a grant is suppressed in the same cycle `drain` rises.
- Results retire in issue order, one per cycle at most.

## Test plan
- **Single requester:** after reset, req0 presents 0x40000000 × 0x40400000 (2.0 × 3.0) at cycle 5 → `req0_ready`=1 at cycle 5; `rsp0_valid`=1 with `rsp0_c`=0x40C00000 at cycle 5+MUL_LAT; `rsp1_valid` never asserts.
- **Contention:** req0 and req1 both valid for 6 cycles (req0: 0x3FC00000 × 0x3FC00000, req1: 0xC0000000 × 0x40800000) → grants alternate 0,1,0,1,0,1; responses alternate with `rsp0_c`=0x40100000 and `rsp1_c`=0xC1000000; `in_flight` peaks at MUL_LAT.
- **Fairness after an idle gap:** req1 wins alone, then both request → req0 is granted first.
- **Drain:** assert `drain` with 3 ops in flight and both requesters valid → no ready while drained; 3 responses retire; `idle`=1 exactly one cycle after the last response; deasserting `drain` resumes grants.
- **Reset mid-flight:** pulse `rst` for 1 cycle with 2 ops in flight → no `rsp*_valid` for those ops; `in_flight`=0 and `idle`=1 the cycle after reset.
- **Counter boundary:** a grant coinciding with a retire holds `in_flight` unchanged; back-to-back single-requester grants for 20 cycles → `in_flight` saturates at MUL_LAT and never exceeds it.
